// File: rtl/dispatch_ctrl.sv
// Dispatch stage: moves one decoded entry per cycle from the instruction queue into a
// single dispatch register and fires it into a reservation station with ROB/free-list allocation.
module dispatch_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_FU     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  iq_is_empty,
  output logic                  iq_dequeue,
  input  logic [DATA_WIDTH-1:0] iq_rdata,
  input  logic                  rob_full,
  input  logic                  rob_empty,
  input  logic [NUM_FU-1:0]     rs_full,
  input  logic                  fl_empty,
  output logic                  disp_valid,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic [NUM_FU-1:0]     disp_rs_sel,
  output logic                  rob_alloc,
  output logic                  fl_alloc,
  output logic [31:0]           stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SERIAL = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  disp_valid_q, disp_valid_d;
  logic [DATA_WIDTH-1:0] disp_data_q, disp_data_d;
  logic [31:0]           stall_q, stall_d;

  logic [1:0]            fu_sel;
  logic                  has_rd;
  logic                  serialize;
  logic                  ready;
  logic                  permit;
  logic                  fire;
  logic                  deq;
  logic [NUM_FU-1:0]     fu_onehot;

  assign fu_sel    = disp_data_q[1:0];
  assign has_rd    = disp_data_q[2];
  assign serialize = disp_data_q[3];
  assign fu_onehot = {{(NUM_FU-1){1'b0}}, 1'b1} << fu_sel;

  assign ready = !rob_full && !rs_full[fu_sel] && (!has_rd || !fl_empty);

  // Serialize entries wait in DRAIN for an empty ROB; SERIAL blocks the next entry
  // until the serialized instruction has left the ROB.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    permit = 1'b0;
    case (state_q)
      RUN:     permit = !serialize;
      DRAIN:   permit = rob_empty;
      default: permit = 1'b0;
    endcase
  end

  assign fire       = disp_valid_q && ready && permit && !flush;
  assign deq        = !iq_is_empty && !flush && (!disp_valid_q || fire);

  assign iq_dequeue   = deq;
  assign disp_valid   = disp_valid_q;
  assign disp_data    = disp_data_q;
  assign disp_rs_sel  = fire ? fu_onehot : '0;
  assign rob_alloc    = fire;
  assign fl_alloc     = fire && has_rd;
  assign stall_cycles = stall_q;

  always_comb begin
    state_d      = state_q;
    disp_valid_d = disp_valid_q;
    disp_data_d  = disp_data_q;
    stall_d      = stall_q;

    if (deq) begin
      disp_valid_d = 1'b1;
      disp_data_d  = iq_rdata;
    end else if (fire) begin
      disp_valid_d = 1'b0;
    end

    if (disp_valid_q && !fire && !flush && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end

    case (state_q)
      RUN:     if (disp_valid_q && serialize) state_d = DRAIN;
      DRAIN:   if (fire) state_d = SERIAL;
      SERIAL:  if (rob_empty) state_d = RUN;
      default: state_d = RUN;
    endcase

    // Flush wins over capture, fire and any state transition in the same cycle.
    if (flush) begin
      disp_valid_d = 1'b0;
      state_d      = RUN;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= RUN;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      stall_q      <= stall_d;
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: stimulus pushes expected fires into a scoreboard,
// a negedge monitor pops and compares whenever the DUT fires.
module tb_dispatch_ctrl;

  localparam int DW = 32;
  localparam int NF = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          iq_is_empty;
  logic          iq_dequeue;
  logic [DW-1:0] iq_rdata;
  logic          rob_full;
  logic          rob_empty;
  logic [NF-1:0] rs_full;
  logic          fl_empty;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic [NF-1:0] disp_rs_sel;
  logic          rob_alloc;
  logic          fl_alloc;
  logic [31:0]   stall_cycles;

  dispatch_ctrl #(.DATA_WIDTH(DW), .NUM_FU(NF)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .iq_is_empty  (iq_is_empty),
    .iq_dequeue   (iq_dequeue),
    .iq_rdata     (iq_rdata),
    .rob_full     (rob_full),
    .rob_empty    (rob_empty),
    .rs_full      (rs_full),
    .fl_empty     (fl_empty),
    .disp_valid   (disp_valid),
    .disp_data    (disp_data),
    .disp_rs_sel  (disp_rs_sel),
    .rob_alloc    (rob_alloc),
    .fl_alloc     (fl_alloc),
    .stall_cycles (stall_cycles)
  );

  typedef struct packed {
    logic [NF-1:0] rs_sel;
    logic          fl;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] feed[$];
  exp_t          mon_e;
  int            vectors = 0;
  int            fails   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [27:0] pl, input logic ser,
                                        input logic rd, input logic [1:0] fu);
    return {pl, ser, rd, fu};
  endfunction

  task automatic refresh();
    iq_is_empty = (feed.size() == 0);
    iq_rdata    = (feed.size() != 0) ? feed[0] : '0;
  endtask

  // Queue an entry at the instruction-queue tail; if it is expected to fire, record how.
  task automatic load(input logic [DW-1:0] e, input bit will_fire,
                      input logic [NF-1:0] rs, input logic fl);
    exp_t x;
    feed.push_back(e);
    if (will_fire) begin
      x.rs_sel = rs;
      x.fl     = fl;
      x.data   = e;
      sb.push_back(x);
    end
    refresh();
  endtask

  // Finish the current cycle: note the dequeue strobe, cross the edge, update the queue model.
  task automatic step();
    logic d;
    #2;
    d = iq_dequeue;
    @(posedge clk);
    #1;
    if (d && feed.size() != 0) feed.delete(0);
    refresh();
  endtask

  always @(negedge clk) begin
    if (!rst && (rob_alloc || fl_alloc || disp_rs_sel != '0)) begin
      if (sb.size() == 0) begin
        vectors++;
        fails++;
        $display("FAIL unexpected_fire: got rs_sel=%b data=%h expected no fire (t=%0t)",
                 disp_rs_sel, disp_data, $time);
      end else begin
        mon_e = sb.pop_front();
        check("fire_rs_sel", 32'(disp_rs_sel), 32'(mon_e.rs_sel));
        check("fire_fl_alloc", 32'(fl_alloc), 32'(mon_e.fl));
        check("fire_rob_alloc", 32'(rob_alloc), 32'd1);
        check("fire_data", disp_data, mon_e.data);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; rob_full = 1'b0; rob_empty = 1'b1;
    rs_full = '0; fl_empty = 1'b0;
    refresh();
    @(posedge clk); #1;
    check("rst_disp_valid", 32'(disp_valid), 0);
    check("rst_disp_data", disp_data, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_rs_sel", 32'(disp_rs_sel), 0);
    check("rst_rob_alloc", 32'(rob_alloc), 0);
    check("rst_fl_alloc", 32'(fl_alloc), 0);
    check("rst_iq_dequeue", 32'(iq_dequeue), 0);
    step();
    rst = 1'b0;

    // Back-to-back stream, one per station.
    load(mk(28'h00000A0, 1'b0, 1'b1, 2'd0), 1'b1, 4'b0001, 1'b1);
    load(mk(28'h00000A1, 1'b0, 1'b1, 2'd1), 1'b1, 4'b0010, 1'b1);
    load(mk(28'h00000A2, 1'b0, 1'b1, 2'd2), 1'b1, 4'b0100, 1'b1);
    load(mk(28'h00000A3, 1'b0, 1'b1, 2'd3), 1'b1, 4'b1000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("b2b_deq", 32'(iq_dequeue), 1);
      if (i > 0) check("b2b_fire", 32'(rob_alloc), 1);
      step();
    end
    #1;
    check("b2b_tail_deq", 32'(iq_dequeue), 0);
    check("b2b_tail_fire", 32'(rob_alloc), 1);
    step();
    #1;
    check("b2b_empty", 32'(disp_valid), 0);
    check("b2b_stall", stall_cycles, 0);
    step();

    // Reservation-station back-pressure on station 2.
    rs_full = 4'b0100;
    load(mk(28'h00000B0, 1'b0, 1'b1, 2'd2), 1'b1, 4'b0100, 1'b1);
    load(mk(28'h00000B1, 1'b0, 1'b0, 2'd1), 1'b1, 4'b0010, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_no_fire", 32'(rob_alloc), 0);
      check("bp_no_deq", 32'(iq_dequeue), 0);
      step();
    end
    rs_full = '0;
    #1;
    check("bp_stall", stall_cycles, 5);
    check("bp_release_sel", 32'(disp_rs_sel), 32'b0100);
    check("bp_release_deq", 32'(iq_dequeue), 1);
    step();
    step();

    // Free list empty: has_rd entry stalls, has_rd=0 entry goes through.
    fl_empty = 1'b1;
    load(mk(28'h00000C0, 1'b0, 1'b1, 2'd3), 1'b1, 4'b1000, 1'b1);
    load(mk(28'h00000C1, 1'b0, 1'b0, 2'd0), 1'b1, 4'b0001, 1'b0);
    step();
    for (int i = 0; i < 2; i++) begin
      #1;
      check("fl_stall_no_fire", 32'(rob_alloc), 0);
      step();
    end
    fl_empty = 1'b0;
    #1;
    check("fl_stall_count", stall_cycles, 7);
    check("fl_rd_alloc", 32'(fl_alloc), 1);
    step();
    fl_empty = 1'b1;
    #1;
    check("fl_nord_fire", 32'(rob_alloc), 1);
    check("fl_nord_no_alloc", 32'(fl_alloc), 0);
    step();
    fl_empty = 1'b0;
    #1;
    check("fl_done", 32'(disp_valid), 0);
    step();

    // Serialize entry waits for an empty ROB, then blocks the next entry.
    rob_empty = 1'b0;
    load(mk(28'h00000D0, 1'b1, 1'b0, 2'd1), 1'b1, 4'b0010, 1'b0);
    load(mk(28'h00000D1, 1'b0, 1'b1, 2'd2), 1'b1, 4'b0100, 1'b1);
    step();
    for (int i = 0; i < 6; i++) begin
      #1;
      check("ser_drain_no_fire", 32'(rob_alloc), 0);
      step();
    end
    rob_empty = 1'b1;
    #1;
    check("ser_stall", stall_cycles, 13);
    check("ser_fire_sel", 32'(disp_rs_sel), 32'b0010);
    check("ser_fire_deq", 32'(iq_dequeue), 1);
    step();
    rob_empty = 1'b0;
    #1;
    check("ser_next_captured", 32'(disp_valid), 1);
    check("ser_serial_hold", 32'(rob_alloc), 0);
    step();
    #1;
    check("ser_serial_hold2", 32'(rob_alloc), 0);
    step();
    rob_empty = 1'b1;
    #1;
    check("ser_serial_exit", 32'(rob_alloc), 0);
    step();
    #1;
    check("ser_run_fire", 32'(rob_alloc), 1);
    check("ser_stall2", stall_cycles, 16);
    step();

    // Flush in the same cycle as a would-be fire.
    load(mk(28'h00000E0, 1'b0, 1'b1, 2'd0), 1'b0, 4'b0000, 1'b0);
    load(mk(28'h00000E1, 1'b0, 1'b0, 2'd3), 1'b1, 4'b1000, 1'b0);
    step();
    flush = 1'b1;
    #1;
    check("flush_no_deq", 32'(iq_dequeue), 0);
    check("flush_no_fire", 32'(rob_alloc), 0);
    check("flush_no_sel", 32'(disp_rs_sel), 0);
    step();
    flush = 1'b0;
    #1;
    check("flush_cleared", 32'(disp_valid), 0);
    check("flush_stall", stall_cycles, 16);
    check("flush_redeq", 32'(iq_dequeue), 1);
    step();
    step();

    // Flush during DRAIN must return to RUN.
    rob_empty = 1'b0;
    load(mk(28'h00000F0, 1'b1, 1'b0, 2'd0), 1'b0, 4'b0000, 1'b0);
    load(mk(28'h00000F1, 1'b0, 1'b0, 2'd1), 1'b1, 4'b0010, 1'b0);
    step();
    step();
    flush = 1'b1;
    #1;
    check("drain_flush_no_fire", 32'(rob_alloc), 0);
    step();
    flush = 1'b0;
    step();
    #1;
    check("drain_flush_run", 32'(rob_alloc), 1);
    check("drain_flush_stall", stall_cycles, 17);
    step();

    // Reset while SERIAL holds an entry.
    rob_empty = 1'b1;
    load(mk(28'h0000010, 1'b1, 1'b0, 2'd2), 1'b1, 4'b0100, 1'b0);
    load(mk(28'h0000011, 1'b0, 1'b1, 2'd0), 1'b0, 4'b0000, 1'b0);
    step();
    step();
    #1;
    check("rs_ser_fire", 32'(disp_rs_sel), 32'b0100);
    step();
    rob_empty = 1'b0;
    rst = 1'b1;
    #1;
    check("rs_pre_valid", 32'(disp_valid), 1);
    step();
    rst = 1'b0;
    load(mk(28'h0000012, 1'b0, 1'b1, 2'd3), 1'b1, 4'b1000, 1'b1);
    #1;
    check("rs_valid", 32'(disp_valid), 0);
    check("rs_data", disp_data, 0);
    check("rs_stall", stall_cycles, 0);
    check("rs_sel", 32'(disp_rs_sel), 0);
    check("rs_rob_alloc", 32'(rob_alloc), 0);
    check("rs_fl_alloc", 32'(fl_alloc), 0);
    check("rs_deq", 32'(iq_dequeue), 1);
    step();
    #1;
    check("rs_state_run", 32'(rob_alloc), 1);
    step();
    step();
    step();

    check("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
